// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default widths, position-width helper and the
// normalized beat record handed from normalization to rounding.
package fpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int EXP_W_DEF  = 8;

  function automatic int pos_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  typedef struct packed {
    logic                  sign;
    logic [EXP_W_DEF-1:0]  exp;
    logic [DATA_W_DEF-1:0] data;
    logic                  zero;
    logic                  underflow;
  } norm_beat_t;

endpackage

// File: rtl/fpu_norm_pipe_if.sv
// Valid/ready bus of the normalization stage: unnormalized beat in,
// normalized beat out. master = upstream/downstream side, slave = the stage.
interface fpu_norm_pipe_if
  import fpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int POS_W  = pos_w(DATA_W)
);
  logic              i_valid;
  logic              o_ready;
  logic              i_sign;
  logic [EXP_W-1:0]  i_exp;
  logic [DATA_W-1:0] i_data;
  logic [POS_W-1:0]  i_pos_one;
  logic              i_zero_flag;
  logic              o_valid;
  logic              i_ready;
  logic              o_sign;
  logic [EXP_W-1:0]  o_exp;
  logic [DATA_W-1:0] o_data;
  logic              o_zero;
  logic              o_underflow;

  modport master (
    output i_valid, i_sign, i_exp, i_data, i_pos_one, i_zero_flag, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_data, o_zero, o_underflow
  );

  modport slave (
    input  i_valid, i_sign, i_exp, i_data, i_pos_one, i_zero_flag, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_data, o_zero, o_underflow
  );
endinterface

// File: rtl/fpu_lshift.sv
// Combinational logarithmic barrel left shifter, zero fill from the LSB.
module fpu_lshift #(
  parameter int DATA_W = 16,
  parameter int POS_W  = 4
) (
  input  logic [DATA_W-1:0] data,
  input  logic [POS_W-1:0]  amount,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] stage [POS_W+1];

  always_comb begin
    stage[0] = data;
    for (int unsigned i = 0; i < POS_W; i++) begin
      stage[i+1] = amount[i] ? (stage[i] << (1 << i)) : stage[i];
    end
    result = stage[POS_W];
  end
endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage normalization pipeline: S1 holds the beat with its shift amount
// and adjusted exponent, S2 holds the shifted mantissa presented downstream.
module fpu_norm_pipe
  import fpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int POS_W  = pos_w(DATA_W)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  fpu_norm_pipe_if.slave bus
);
  // Same layout as norm_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              underflow;
  } beat_t;

  logic              s1_valid, s2_valid;
  logic              s1_adv, s2_adv, in_xfer;
  beat_t             s1_beat, s2_beat, in_beat;
  logic [POS_W-1:0]  s1_shift, in_shift;
  logic [EXP_W:0]    diff;
  logic              normal;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    s2_adv      = !s2_valid || bus.i_ready;
    s1_adv      = s1_valid && s2_adv;
    bus.o_ready = !s1_valid || s2_adv;
    in_xfer     = bus.i_valid && bus.o_ready;
  end

  // One extra bit on the difference: its MSB flags exp < pos without wrapping.
  always_comb begin
    diff     = {1'b0, bus.i_exp} - (EXP_W+1)'(bus.i_pos_one);
    normal   = !diff[EXP_W] && (diff != '0);
    in_beat  = '0;
    in_shift = '0;
    in_beat.sign = bus.i_sign;
    in_beat.zero = bus.i_zero_flag;
    if (!bus.i_zero_flag) begin
      in_beat.data = bus.i_data;
      if (normal) begin
        in_beat.exp = diff[EXP_W-1:0];
        in_shift    = bus.i_pos_one;
      end else begin
        in_beat.underflow = 1'b1;
        in_shift = (bus.i_exp == '0) ? '0 : POS_W'(bus.i_exp - EXP_W'(1));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_beat  <= '0;
      s1_shift <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_beat  <= in_beat;
      s1_shift <= in_shift;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  fpu_lshift #(
    .DATA_W (DATA_W),
    .POS_W  (POS_W)
  ) u_lshift (
    .data   (s1_beat.data),
    .amount (s1_shift),
    .result (shifted)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_beat  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_beat      <= s1_beat;
        s2_beat.data <= shifted;
      end
    end
  end

  always_comb begin
    bus.o_valid     = s2_valid;
    bus.o_sign      = s2_beat.sign;
    bus.o_exp       = s2_beat.exp;
    bus.o_data      = s2_beat.data;
    bus.o_zero      = s2_beat.zero;
    bus.o_underflow = s2_beat.underflow;
  end
endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Self-checking bench for fpu_norm_pipe: directed vector table, reset and
// throughput sequences, and randomized backpressure against a reference model.
module tb_fpu_norm_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_norm_pipe_if #(.DATA_W(16), .EXP_W(8), .POS_W(4)) bus();

  fpu_norm_pipe #(.DATA_W(16), .EXP_W(8), .POS_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [26:0] res;
    int          cyc;
  } sb_t;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [15:0] data;
    logic [3:0]  pos;
    logic        zf;
    logic [26:0] want;
  } vec_t;

  sb_t         q[$];
  vec_t        tbl[10];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rdy_mode = 0;
  logic        took;
  logic [26:0] cur_exp;
  int          vcount, first_v, last_v;
  logic [3:0]  pattern = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [26:0] outv(logic s, logic [7:0] e, logic [15:0] d, logic z, logic u);
    return {s, e, d, z, u};
  endfunction

  function automatic logic [26:0] pack_out();
    return {bus.o_sign, bus.o_exp, bus.o_data, bus.o_zero, bus.o_underflow};
  endfunction

  // Reference normalization computed straight from the arithmetic rules.
  function automatic logic [26:0] model(logic s, int e, int d, int p, logic z);
    int   sh, eo;
    logic uf;
    if (z) return outv(s, 8'd0, 16'd0, 1'b1, 1'b0);
    if (e > p) begin
      sh = p; eo = e - p; uf = 1'b0;
    end else begin
      sh = (e == 0) ? 0 : e - 1; eo = 0; uf = 1'b1;
    end
    return outv(s, 8'(eo), 16'((d << sh) & 32'hFFFF), 1'b0, uf);
  endfunction

  // One clock: decide i_ready, check at the falling edge, resume after the rising edge.
  task automatic step();
    case (rdy_mode)
      1: bus.i_ready = pattern[cyc % 4];
      2: bus.i_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    @(negedge clk); #1;
    check("o_ready", 64'(bus.o_ready), 64'(!(q.size() == 2 && !bus.i_ready)));
    check("o_valid", 64'(bus.o_valid), 64'(q.size() > 0 && q[0].cyc + 2 <= cyc));
    if (bus.o_valid) begin
      if (vcount == 0) first_v = cyc;
      last_v = cyc;
      vcount++;
    end
    if (bus.o_valid && bus.i_ready && q.size() > 0) begin
      check("payload", 64'(pack_out()), 64'(q[0].res));
      void'(q.pop_front());
    end
    took = bus.i_valid && bus.o_ready;
    if (took) q.push_back('{res: cur_exp, cyc: cyc});
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send_beat(input logic s, input logic [7:0] e, input logic [15:0] d,
                           input logic [3:0] p, input logic z, input logic [26:0] want);
    bus.i_sign = s; bus.i_exp = e; bus.i_data = d; bus.i_pos_one = p;
    bus.i_zero_flag = z; bus.i_valid = 1'b1; cur_exp = want; took = 1'b0;
    for (int n = 0; n < 20 && !took; n++) step();
    check("send_accept", 64'(took), 64'd1);
  endtask

  task automatic send_random();
    logic       s, z;
    logic [7:0] e;
    logic [3:0] p;
    int         d;
    s = 1'($urandom_range(0, 1));
    z = ($urandom_range(0, 9) == 0);
    p = 4'($urandom_range(0, 15));
    e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 16)) : 8'($urandom_range(0, 255));
    d = z ? 0 : ((1 << (15 - p)) | (int'($urandom) & ((1 << (15 - p)) - 1)));
    send_beat(s, e, 16'(d), p, z, model(s, e, d, p, z));
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    rdy_mode = 0;
    bus.i_ready = 1'b1;
    for (int n = 0; n < 12 && q.size() > 0; n++) step();
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_sign = 1'b0; bus.i_exp = '0;
    bus.i_data = '0; bus.i_pos_one = '0; bus.i_zero_flag = 1'b0;
    vcount = 0; first_v = 0; last_v = 0; cur_exp = '0; took = 1'b0;

    tbl[0] = '{1'b0, 8'd20,  16'h0123, 4'd7,  1'b0, outv(1'b0, 8'd13,  16'h9180, 1'b0, 1'b0)};
    tbl[1] = '{1'b0, 8'd5,   16'h0010, 4'd11, 1'b0, outv(1'b0, 8'd0,   16'h0100, 1'b0, 1'b1)};
    tbl[2] = '{1'b1, 8'd0,   16'h1234, 4'd3,  1'b0, outv(1'b1, 8'd0,   16'h1234, 1'b0, 1'b1)};
    tbl[3] = '{1'b1, 8'd100, 16'hABCD, 4'd5,  1'b1, outv(1'b1, 8'd0,   16'h0000, 1'b1, 1'b0)};
    tbl[4] = '{1'b0, 8'd1,   16'h8000, 4'd0,  1'b0, outv(1'b0, 8'd1,   16'h8000, 1'b0, 1'b0)};
    tbl[5] = '{1'b0, 8'd15,  16'h0001, 4'd15, 1'b0, outv(1'b0, 8'd0,   16'h4000, 1'b0, 1'b1)};
    tbl[6] = '{1'b0, 8'd16,  16'h0001, 4'd15, 1'b0, outv(1'b0, 8'd1,   16'h8000, 1'b0, 1'b0)};
    tbl[7] = '{1'b0, 8'd255, 16'h00F0, 4'd8,  1'b0, outv(1'b0, 8'd247, 16'hF000, 1'b0, 1'b0)};
    tbl[8] = '{1'b1, 8'd1,   16'h0003, 4'd14, 1'b0, outv(1'b1, 8'd0,   16'h0003, 1'b0, 1'b1)};
    tbl[9] = '{1'b0, 8'd0,   16'h0000, 4'd0,  1'b1, outv(1'b0, 8'd0,   16'h0000, 1'b1, 1'b0)};

    repeat (3) @(posedge clk);
    #1 check("reset_outs", 64'({bus.o_valid, pack_out()}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    step();

    // Directed vectors, back to back.
    for (int k = 0; k < 10; k++)
      send_beat(tbl[k].sign, tbl[k].exp, tbl[k].data, tbl[k].pos, tbl[k].zf, tbl[k].want);
    drain();

    // Reset with two beats stalled inside the pipe.
    bus.i_ready = 1'b0;
    send_beat(1'b0, 8'd20, 16'h0123, 4'd7, 1'b0, outv(1'b0, 8'd13, 16'h9180, 1'b0, 1'b0));
    send_beat(1'b1, 8'd30, 16'h00FF, 4'd8, 1'b0, outv(1'b1, 8'd22, 16'hFF00, 1'b0, 1'b0));
    bus.i_valid = 1'b0;
    step();
    check("stalled_occupancy", 64'(q.size()), 64'd2);
    rst_n = 1'b0;
    #1 check("midstream_reset_outs", 64'({bus.o_valid, pack_out()}), 64'd0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    repeat (5) step();

    // Backpressure 1,0,0,1,... with random beats.
    rdy_mode = 1;
    for (int k = 0; k < 10; k++) send_random();
    drain();

    // Full throughput.
    vcount = 0;
    for (int k = 0; k < 32; k++) send_random();
    drain();
    check("throughput_count", 64'(vcount), 64'd32);
    check("throughput_run", 64'(last_v - first_v + 1), 64'd32);

    // Random handshakes on both sides.
    rdy_mode = 2;
    for (int k = 0; k < 80; k++) begin
      send_random();
      if ($urandom_range(0, 3) == 0) begin
        bus.i_valid = 1'b0;
        step();
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
